// File: rtl/multi_edge_detect_pkg.sv
// Shared definitions for the multi-channel edge detector: edge-mode encodings
// and the helper that decides whether a level toggle qualifies for a pulse.
package edge_pkg;

   localparam logic [1:0] MODE_OFF  = 2'b00;
   localparam logic [1:0] MODE_RISE = 2'b01;
   localparam logic [1:0] MODE_FALL = 2'b10;
   localparam logic [1:0] MODE_BOTH = 2'b11;

   // A rising toggle needs the rise bit of the mode, a falling toggle the fall bit.
   function automatic logic edge_qualifies(input logic [1:0] mode, input logic rising);
      logic [1:0] needed;
      needed = rising ? MODE_RISE : MODE_FALL;
      return (mode & needed) != MODE_OFF;
   endfunction

endpackage

// File: rtl/multi_edge_detect_if.sv
// Channel bus of the edge detector: raw inputs and controls towards the
// detector, filtered levels, pulses, status and interrupt back out.
interface multi_edge_detect_if #(
   parameter int WIDTH = 4
);

   logic [WIDTH-1:0]   in;
   logic [2*WIDTH-1:0] mode;
   logic [WIDTH-1:0]   irq_en;
   logic [WIDTH-1:0]   clear;
   logic [WIDTH-1:0]   level;
   logic [WIDTH-1:0]   edge_pulse;
   logic [WIDTH-1:0]   status;
   logic               irq;

   modport master (
      output in, mode, irq_en, clear,
      input  level, edge_pulse, status, irq
   );

   modport slave (
      input  in, mode, irq_en, clear,
      output level, edge_pulse, status, irq
   );

endinterface

// File: rtl/multi_edge_detect_chan.sv
// One channel: synchroniser chain, debounce counter, filtered level,
// mode-qualified one-cycle pulse and sticky status flag.
module edge_chan
   import edge_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       in_i,
   input  logic [1:0] mode_i,
   input  logic       clear_i,
   output logic       level_o,
   output logic       pulse_o,
   output logic       status_o
);

   localparam int CntW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CntW-1:0]        count_q, count_d;
   logic                   level_q, level_d;
   logic                   pulse_q, pulse_d;
   logic                   status_q, status_d;
   logic                   toggle;

   // The level only flips once the synchronised input has disagreed with it
   // for DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], in_i};
      count_d = '0;
      level_d = level_q;
      toggle  = 1'b0;
      if (sync_q[SYNC_STAGES-1] != level_q) begin
         if (count_q == CntLast) begin
            toggle  = 1'b1;
            level_d = ~level_q;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
      pulse_d  = toggle && edge_qualifies(mode_i, ~level_q);
      status_d = pulse_d ? 1'b1 : (clear_i ? 1'b0 : status_q);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q   <= '0;
         count_q  <= '0;
         level_q  <= 1'b0;
         pulse_q  <= 1'b0;
         status_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         count_q  <= count_d;
         level_q  <= level_d;
         pulse_q  <= pulse_d;
         status_q <= status_d;
      end
   end

   assign level_o  = level_q;
   assign pulse_o  = pulse_q;
   assign status_o = status_q;

endmodule

// File: rtl/multi_edge_detect.sv
// Multi-channel edge detector: WIDTH independent debounced channels plus a
// maskable interrupt formed from their sticky status flags.
module multi_edge_detect
   import edge_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1
) (
   input logic                clock,
   input logic                reset,
   multi_edge_detect_if.slave bus
);

   logic [WIDTH-1:0] levelW;
   logic [WIDTH-1:0] pulseW;
   logic [WIDTH-1:0] statusW;

   // Channels share nothing but the clock and reset.
   for (genvar i = 0; i < WIDTH; i++) begin : gChan
      edge_chan #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) uChan (
         .clock   (clock),
         .reset   (reset),
         .in_i    (bus.in[i]),
         .mode_i  (bus.mode[2*i +: 2]),
         .clear_i (bus.clear[i]),
         .level_o (levelW[i]),
         .pulse_o (pulseW[i]),
         .status_o(statusW[i])
      );
   end

   // The enable mask acts combinationally so software can gate irq instantly.
   assign bus.level      = levelW;
   assign bus.edge_pulse = pulseW;
   assign bus.status     = statusW;
   assign bus.irq        = |(statusW & bus.irq_en);

endmodule

// File: tb/tb_multi_edge_detect.sv
// Bench for multi_edge_detect: directed scenarios with literal expectations,
// then random traffic compared every cycle against a history-window model.
module tb_multi_edge_detect;
   import edge_pkg::*;

   localparam int W = 4;
   localparam int S = 2;
   localparam int N = 3;
   localparam int HistLen = S + N - 1;

   logic clock;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic checkEnable = 1'b0;

   multi_edge_detect_if #(.WIDTH(W)) bus ();

   multi_edge_detect #(
      .WIDTH          (W),
      .SYNC_STAGES    (S),
      .DEBOUNCE_CYCLES(N)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [W-1:0] hist [HistLen];
   logic [W-1:0] mLevel, mPulse, mStatus;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [W-1:0] inV, input logic [2*W-1:0] modeV,
                                input logic [W-1:0] irqEnV, input logic [W-1:0] clearV);
      reset      = r;
      bus.in     = inV;
      bus.mode   = modeV;
      bus.irq_en = irqEnV;
      bus.clear  = clearV;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
      #1;
   endtask

   // Model: a level flips when every synchronised sample in the last N edges
   // disagreed with it; the synchronised sample at an edge is the raw input
   // taken S edges earlier.
   always @(posedge clock) begin
      logic allDiffer;
      if (reset) begin
         for (int j = 0; j < HistLen; j++) hist[j] = '0;
         mLevel      = '0;
         mPulse      = '0;
         mStatus     = '0;
         checkEnable = 1'b1;
      end else begin
         for (int i = 0; i < W; i++) begin
            allDiffer = 1'b1;
            for (int j = S - 1; j <= S + N - 2; j++)
               if (hist[j][i] == mLevel[i]) allDiffer = 1'b0;
            mPulse[i] = 1'b0;
            if (allDiffer) begin
               mPulse[i] = mLevel[i] ? bus.mode[2*i+1] : bus.mode[2*i];
               mLevel[i] = ~mLevel[i];
            end
            mStatus[i] = mPulse[i] | (mStatus[i] & ~bus.clear[i]);
         end
         for (int j = HistLen - 1; j > 0; j--) hist[j] = hist[j-1];
         hist[0] = bus.in;
      end
   end

   always @(negedge clock) begin
      if (checkEnable) begin
         checkOutput("level", 32'(bus.level), 32'(mLevel));
         checkOutput("edge_pulse", 32'(bus.edge_pulse), 32'(mPulse));
         checkOutput("status", 32'(bus.status), 32'(mStatus));
         checkOutput("irq", 32'(bus.irq), 32'(|(mStatus & bus.irq_en)));
      end
   end

   localparam logic [2*W-1:0] ModeInit = {MODE_OFF, MODE_BOTH, MODE_FALL, MODE_RISE};
   localparam logic [2*W-1:0] ModeT5   = {MODE_OFF, MODE_RISE, MODE_RISE, MODE_RISE};

   initial begin
      int pulseCount;
      logic [W-1:0] nIn, nClear;
      @(negedge clock);
      #1;
      applyStimulus(1'b1, 4'b0000, ModeInit, 4'b0001, 4'b0000);
      cycles(2);
      applyStimulus(1'b0, 4'b0000, ModeInit, 4'b0001, 4'b0000);
      checkOutput("reset_level", 32'(bus.level), 32'h0);
      checkOutput("reset_status", 32'(bus.status), 32'h0);
      checkOutput("reset_irq", 32'(bus.irq), 32'h0);
      cycles(3);

      $display("[TB] rise on channel 0");
      applyStimulus(1'b0, 4'b0001, ModeInit, 4'b0001, 4'b0000);
      cycles(4);
      checkOutput("t1_edge4_level", 32'(bus.level[0]), 32'h0);
      checkOutput("t1_edge4_pulse", 32'(bus.edge_pulse[0]), 32'h0);
      cycles(1);
      checkOutput("t1_edge5_level", 32'(bus.level[0]), 32'h1);
      checkOutput("t1_edge5_pulse", 32'(bus.edge_pulse[0]), 32'h1);
      cycles(1);
      checkOutput("t1_edge6_pulse", 32'(bus.edge_pulse[0]), 32'h0);
      checkOutput("t1_status", 32'(bus.status[0]), 32'h1);
      pulseCount = 0;
      for (int k = 0; k < 10; k++) begin
         cycles(1);
         pulseCount += int'(bus.edge_pulse[0]);
      end
      checkOutput("t1_no_second_pulse", 32'(pulseCount), 32'h0);

      $display("[TB] status clear and irq");
      checkOutput("t4_irq_set", 32'(bus.irq), 32'h1);
      applyStimulus(1'b0, 4'b0001, ModeInit, 4'b0001, 4'b0001);
      cycles(1);
      applyStimulus(1'b0, 4'b0001, ModeInit, 4'b0001, 4'b0000);
      checkOutput("t4_status_cleared", 32'(bus.status[0]), 32'h0);
      checkOutput("t4_irq_cleared", 32'(bus.irq), 32'h0);
      applyStimulus(1'b0, 4'b0000, ModeInit, 4'b0001, 4'b0000);
      cycles(6);
      checkOutput("t4_fall_no_pulse", 32'(bus.status[0]), 32'h0);
      applyStimulus(1'b0, 4'b0001, ModeInit, 4'b0001, 4'b0000);
      cycles(4);
      applyStimulus(1'b0, 4'b0001, ModeInit, 4'b0001, 4'b0001);
      cycles(1);
      applyStimulus(1'b0, 4'b0001, ModeInit, 4'b0001, 4'b0000);
      checkOutput("t4_set_wins_pulse", 32'(bus.edge_pulse[0]), 32'h1);
      checkOutput("t4_set_wins_status", 32'(bus.status[0]), 32'h1);

      $display("[TB] fall mode on channel 1");
      applyStimulus(1'b0, 4'b0011, ModeInit, 4'b0001, 4'b0000);
      cycles(5);
      checkOutput("t2_rise_level", 32'(bus.level[1]), 32'h1);
      checkOutput("t2_rise_no_pulse", 32'(bus.edge_pulse[1]), 32'h0);
      applyStimulus(1'b0, 4'b0001, ModeInit, 4'b0001, 4'b0000);
      cycles(5);
      checkOutput("t2_fall_level", 32'(bus.level[1]), 32'h0);
      checkOutput("t2_fall_pulse", 32'(bus.edge_pulse[1]), 32'h1);

      $display("[TB] glitch and both-edge mode on channel 2");
      applyStimulus(1'b0, 4'b0101, ModeInit, 4'b0001, 4'b0000);
      cycles(2);
      applyStimulus(1'b0, 4'b0001, ModeInit, 4'b0001, 4'b0000);
      cycles(8);
      checkOutput("t3_glitch_level", 32'(bus.level[2]), 32'h0);
      checkOutput("t3_glitch_status", 32'(bus.status[2]), 32'h0);
      pulseCount = 0;
      applyStimulus(1'b0, 4'b0101, ModeInit, 4'b0001, 4'b0000);
      for (int k = 0; k < 10; k++) begin
         cycles(1);
         pulseCount += int'(bus.edge_pulse[2]);
      end
      applyStimulus(1'b0, 4'b0001, ModeInit, 4'b0001, 4'b0000);
      for (int k = 0; k < 10; k++) begin
         cycles(1);
         pulseCount += int'(bus.edge_pulse[2]);
      end
      checkOutput("t3_two_pulses", 32'(pulseCount), 32'h2);

      $display("[TB] simultaneous edges");
      applyStimulus(1'b0, 4'b0000, ModeT5, 4'b0001, 4'b0000);
      cycles(6);
      applyStimulus(1'b0, 4'b1111, ModeT5, 4'b0001, 4'b0000);
      cycles(5);
      checkOutput("t5_pulses", 32'(bus.edge_pulse), 32'h7);
      checkOutput("t5_level", 32'(bus.level), 32'hF);

      $display("[TB] reset during debounce");
      applyStimulus(1'b0, 4'b0000, ModeT5, 4'b0001, 4'b0000);
      cycles(6);
      applyStimulus(1'b0, 4'b1111, ModeT5, 4'b0001, 4'b0000);
      cycles(3);
      applyStimulus(1'b1, 4'b1111, ModeT5, 4'b0001, 4'b0000);
      cycles(1);
      applyStimulus(1'b0, 4'b1111, ModeT5, 4'b0001, 4'b0000);
      checkOutput("t6_reset_level", 32'(bus.level), 32'h0);
      checkOutput("t6_reset_pulse", 32'(bus.edge_pulse), 32'h0);
      checkOutput("t6_reset_status", 32'(bus.status), 32'h0);
      checkOutput("t6_reset_irq", 32'(bus.irq), 32'h0);
      cycles(4);
      checkOutput("t6_edge4_pulse", 32'(bus.edge_pulse), 32'h0);
      cycles(1);
      checkOutput("t6_edge5_pulse", 32'(bus.edge_pulse), 32'h7);

      $display("[TB] random traffic");
      for (int c = 0; c < 4000; c++) begin
         nIn = bus.in;
         for (int i = 0; i < W; i++)
            if ($urandom_range(0, 5) == 0) nIn[i] = ~nIn[i];
         nClear = '0;
         for (int i = 0; i < W; i++)
            if ($urandom_range(0, 7) == 0) nClear[i] = 1'b1;
         applyStimulus(($urandom_range(0, 299) == 0),
                       nIn,
                       ($urandom_range(0, 19) == 0) ? (2*W)'($urandom) : bus.mode,
                       ($urandom_range(0, 9) == 0) ? W'($urandom) : bus.irq_en,
                       nClear);
         cycles(1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
